// File: rtl/idu_is_lsiq_ctrl_pkg.sv
// Shared LSIQ sizing and issue-payload field layout for the load/store issue queue control slice.
package idu_is_lsiq_ctrl_pkg;

    localparam int LSIQ_ENTRY_NUM = 8;
    localparam int LSIQ_PAYLOAD_W = 160;

    localparam int LSIQ_IID_OFS    = 0;
    localparam int LSIQ_OPCODE_OFS = 7;
    localparam int LSIQ_FUNCT7_OFS = 14;
    localparam int LSIQ_FUNCT3_OFS = 21;
    localparam int LSIQ_PSRC1_OFS  = 24;
    localparam int LSIQ_PSRC2_OFS  = 31;
    localparam int LSIQ_PDST_OFS   = 38;
    localparam int LSIQ_IMM_OFS    = 45;
    localparam int LSIQ_PC_OFS     = 77;

    // Field order mirrors the *_OFS constants, LSB (iid) last.
    typedef struct packed {
        logic [18:0] rsvd;
        logic [63:0] pc;
        logic [31:0] imm;
        logic [6:0]  pdst;
        logic [6:0]  psrc2;
        logic [6:0]  psrc1;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [6:0]  opcode;
        logic [6:0]  iid;
    } lsiq_payload_t;

endpackage

// File: rtl/idu_is_lsiq_ctrl_if.sv
// Dispatch, entry-array and LSU-side signals of the LSIQ controller bundled as one interface.
interface idu_is_lsiq_ctrl_if
    import idu_is_lsiq_ctrl_pkg::*;
#(
    parameter int ENTRY_NUM = LSIQ_ENTRY_NUM,
    parameter int PAYLOAD_W = LSIQ_PAYLOAD_W
);
    logic                           rtu_global_flush;
    logic                           dp_lsiq_create;
    logic                           lsiq_dp_full;
    logic [ENTRY_NUM-1:0]           create_sel;
    logic [ENTRY_NUM-1:0]           entry_vld;
    logic [ENTRY_NUM-1:0]           entry_ready;
    logic [ENTRY_NUM*PAYLOAD_W-1:0] entry_payload;
    logic [ENTRY_NUM-1:0]           issue_sel;
    logic                           lsiq_lsu_vld;
    logic [PAYLOAD_W-1:0]           lsiq_lsu_payload;
    logic                           lsu_lsiq_rdy;

    // The controller is the slave; dispatch, entries and LSU together form the master side.
    modport slave (
        input  rtu_global_flush, dp_lsiq_create, entry_vld, entry_ready, entry_payload, lsu_lsiq_rdy,
        output lsiq_dp_full, create_sel, issue_sel, lsiq_lsu_vld, lsiq_lsu_payload
    );

    modport master (
        output rtu_global_flush, dp_lsiq_create, entry_vld, entry_ready, entry_payload, lsu_lsiq_rdy,
        input  lsiq_dp_full, create_sel, issue_sel, lsiq_lsu_vld, lsiq_lsu_payload
    );

endinterface

// File: rtl/idu_is_lsiq_age_matrix.sv
// NxN age matrix for the LSIQ: age_q[i][j]=1 means entry j is older than entry i; picks the oldest candidate.
module idu_is_lsiq_age_matrix #(
    parameter int ENTRY_NUM = 8,
    parameter int INORDER   = 0
) (
    input  logic                 clk,
    input  logic                 rst_clk,
    input  logic                 flush_i,
    input  logic [ENTRY_NUM-1:0] create_sel_i,
    input  logic [ENTRY_NUM-1:0] entry_vld_i,
    input  logic [ENTRY_NUM-1:0] ready_i,
    output logic [ENTRY_NUM-1:0] pick_o
);

    logic [ENTRY_NUM-1:0][ENTRY_NUM-1:0] age_q;
    logic [ENTRY_NUM-1:0][ENTRY_NUM-1:0] age_d;
    logic [ENTRY_NUM-1:0]                oldest_vld;
    logic [ENTRY_NUM-1:0]                cand;

    // A new entry is younger than everything valid now; nobody is younger than it yet.
    always_comb begin
        age_d = age_q;
        if (flush_i) begin
            age_d = '0;
        end else begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                for (int j = 0; j < ENTRY_NUM; j++) begin
                    if (create_sel_i[i]) begin
                        age_d[i][j] = entry_vld_i[j];
                    end else if (create_sel_i[j]) begin
                        age_d[i][j] = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst_clk) begin
        if (rst_clk) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

    // Stale bits of issued/invalid entries are harmless because every row is masked here.
    always_comb begin
        oldest_vld = '0;
        pick_o     = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            oldest_vld[i] = entry_vld_i[i] & ~|(age_q[i] & entry_vld_i);
        end
        cand = (INORDER != 0) ? (ready_i & oldest_vld) : ready_i;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            pick_o[i] = cand[i] & ~|(age_q[i] & cand);
        end
    end

endmodule

// File: rtl/idu_is_lsiq_ctrl.sv
// LSIQ control: free-entry allocation, oldest-ready issue select and the registered LSU issue stage.
module idu_is_lsiq_ctrl
    import idu_is_lsiq_ctrl_pkg::*;
#(
    parameter int ENTRY_NUM = LSIQ_ENTRY_NUM,
    parameter int PAYLOAD_W = LSIQ_PAYLOAD_W,
    parameter int INORDER   = 0
) (
    input  logic              clk,
    input  logic              rst_clk,
    idu_is_lsiq_ctrl_if.slave lsiq_if
);

    logic [ENTRY_NUM-1:0] free_vec;
    logic [ENTRY_NUM-1:0] create_first;
    logic [ENTRY_NUM-1:0] create_sel;
    logic [ENTRY_NUM-1:0] pick;
    logic [ENTRY_NUM-1:0] issue_sel;
    logic                 stage_free;
    logic [PAYLOAD_W-1:0] issue_payload;
    logic                 lsu_vld_d;
    logic                 lsu_vld_q;
    logic [PAYLOAD_W-1:0] lsu_payload_d;
    logic [PAYLOAD_W-1:0] lsu_payload_q;

    // Isolating the lowest set bit of the free vector gives the lowest-index free entry.
    assign free_vec     = ~lsiq_if.entry_vld;
    assign create_first = free_vec & (~free_vec + ENTRY_NUM'(1));
    assign create_sel   = create_first & {ENTRY_NUM{lsiq_if.dp_lsiq_create & ~lsiq_if.rtu_global_flush}};

    assign lsiq_if.lsiq_dp_full = &lsiq_if.entry_vld;
    assign lsiq_if.create_sel   = create_sel;

    idu_is_lsiq_age_matrix #(
        .ENTRY_NUM (ENTRY_NUM),
        .INORDER   (INORDER)
    ) u_age_matrix (
        .clk          (clk),
        .rst_clk      (rst_clk),
        .flush_i      (lsiq_if.rtu_global_flush),
        .create_sel_i (create_sel),
        .entry_vld_i  (lsiq_if.entry_vld),
        .ready_i      (lsiq_if.entry_ready),
        .pick_o       (pick)
    );

    assign stage_free = ~lsu_vld_q | lsiq_if.lsu_lsiq_rdy;
    assign issue_sel  = pick & {ENTRY_NUM{stage_free & ~lsiq_if.rtu_global_flush}};

    assign lsiq_if.issue_sel = issue_sel;

    always_comb begin
        issue_payload = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            issue_payload = issue_payload
                          | ({PAYLOAD_W{issue_sel[i]}} & lsiq_if.entry_payload[i*PAYLOAD_W +: PAYLOAD_W]);
        end
    end

    // Flush beats a same-cycle LSU accept; the payload only moves when a new entry is loaded.
    always_comb begin
        lsu_vld_d     = lsu_vld_q;
        lsu_payload_d = lsu_payload_q;
        if (lsiq_if.rtu_global_flush) begin
            lsu_vld_d = 1'b0;
        end else if (|issue_sel) begin
            lsu_vld_d     = 1'b1;
            lsu_payload_d = issue_payload;
        end else if (lsiq_if.lsu_lsiq_rdy) begin
            lsu_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst_clk) begin
        if (rst_clk) begin
            lsu_vld_q     <= 1'b0;
            lsu_payload_q <= '0;
        end else begin
            lsu_vld_q     <= lsu_vld_d;
            lsu_payload_q <= lsu_payload_d;
        end
    end

    assign lsiq_if.lsiq_lsu_vld     = lsu_vld_q;
    assign lsiq_if.lsiq_lsu_payload = lsu_payload_q;

`ifndef SYNTHESIS
    a_create_onehot : assert property (@(posedge clk) disable iff (rst_clk) $onehot0(create_sel));
    a_issue_onehot  : assert property (@(posedge clk) disable iff (rst_clk) $onehot0(issue_sel));
    a_create_free   : assert property (@(posedge clk) disable iff (rst_clk) ~|(create_sel & lsiq_if.entry_vld));
    a_no_full_create: assert property (@(posedge clk) disable iff (rst_clk)
                                       !(lsiq_if.dp_lsiq_create && lsiq_if.lsiq_dp_full));
`endif

endmodule

// File: tb/tb_idu_is_lsiq_ctrl.sv
// Drives an out-of-order (dut0) and an in-order (dut1) LSIQ controller against a creation-stamp model of the queue.
module tb_idu_is_lsiq_ctrl;
    import idu_is_lsiq_ctrl_pkg::*;

    localparam int EN = LSIQ_ENTRY_NUM;
    localparam int PW = LSIQ_PAYLOAD_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]               flushS, createS, rdyS;
    logic [1:0][EN-1:0]       vldS, readyS;
    logic [1:0][EN*PW-1:0]    payBus;
    logic [1:0]               fullO, lsuVldO;
    logic [1:0][EN-1:0]       createO, issueO;
    logic [1:0][PW-1:0]       lsuPayO;

    for (genvar g = 0; g < 2; g++) begin : gDut
        idu_is_lsiq_ctrl_if #(.ENTRY_NUM(EN), .PAYLOAD_W(PW)) ifc ();
        assign ifc.rtu_global_flush = flushS[g];
        assign ifc.dp_lsiq_create   = createS[g];
        assign ifc.entry_vld        = vldS[g];
        assign ifc.entry_ready      = readyS[g];
        assign ifc.entry_payload    = payBus[g];
        assign ifc.lsu_lsiq_rdy     = rdyS[g];
        assign fullO[g]             = ifc.lsiq_dp_full;
        assign createO[g]           = ifc.create_sel;
        assign issueO[g]            = ifc.issue_sel;
        assign lsuVldO[g]           = ifc.lsiq_lsu_vld;
        assign lsuPayO[g]           = ifc.lsiq_lsu_payload;
        idu_is_lsiq_ctrl #(.ENTRY_NUM(EN), .PAYLOAD_W(PW), .INORDER(g)) dut (
            .clk     (clk),
            .rst_clk (rst),
            .lsiq_if (ifc.slave)
        );
    end

    // Model state: which entries hold an op, when each was created, and the LSU stage contents.
    logic [EN-1:0]   mVld [2];
    int unsigned     mStamp [2][EN];
    logic [PW-1:0]   mPay [2][EN];
    logic            lsuVld [2];
    logic [PW-1:0]   lsuPay [2];
    int unsigned     stampCtr = 0;

    bit              sCreate [2], sRdy [2], sFlush [2];
    logic [EN-1:0]   sReady [2];
    int              nextPick [2], nextCreate [2];
    logic            obsFull [2], obsLsuVld [2];
    logic [EN-1:0]   obsCreate [2], obsIssue [2];
    logic [PW-1:0]   obsLsuPay [2];

    int checkCount = 0;
    int errCount   = 0;
    logic [PW-1:0] savedPay;

    function automatic logic [PW-1:0] randPay();
        lsiq_payload_t p;
        p     = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        p.iid = 7'(stampCtr);
        return p;
    endfunction

    // Oldest ready entry (out-of-order) or the oldest valid entry if it is ready (in-order).
    function automatic int pickOldest(int m);
        int best   = -1;
        int oldest = -1;
        for (int i = 0; i < EN; i++) begin
            if (mVld[m][i] && (oldest < 0 || mStamp[m][i] < mStamp[m][oldest])) oldest = i;
            if (readyS[m][i] && (best < 0 || mStamp[m][i] < mStamp[m][best])) best = i;
        end
        if (m == 1) best = (oldest >= 0 && readyS[m][oldest]) ? oldest : -1;
        return best;
    endfunction

    task automatic checkOutput(input string name, input int m, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checkCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s dut%0d actual=%0h required=%0h", name, m, act, exp);
        end
    endtask

    task automatic setStim(input bit c, input logic [EN-1:0] rd, input bit r, input bit f);
        for (int m = 0; m < 2; m++) begin
            sCreate[m] = c;
            sReady[m]  = rd;
            sRdy[m]    = r;
            sFlush[m]  = f;
        end
    endtask

    task automatic applyStimulus();
        for (int m = 0; m < 2; m++) begin
            vldS[m]    = mVld[m];
            readyS[m]  = sReady[m] & mVld[m];
            createS[m] = sCreate[m] & ~(&mVld[m]);
            flushS[m]  = sFlush[m];
            rdyS[m]    = sRdy[m];
            for (int i = 0; i < EN; i++) payBus[m][i*PW +: PW] = mPay[m][i];
        end
    endtask

    task automatic runCycle();
        int pick, cIdx;
        logic [EN-1:0] expCreate, expIssue;
        applyStimulus();
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            cIdx = -1;
            if (createS[m] && !flushS[m])
                for (int i = EN - 1; i >= 0; i--) if (!mVld[m][i]) cIdx = i;
            pick = pickOldest(m);
            if (flushS[m] || !(!lsuVld[m] || rdyS[m])) pick = -1;
            expCreate = (cIdx >= 0) ? EN'(1 << cIdx) : '0;
            expIssue  = (pick >= 0) ? EN'(1 << pick) : '0;
            obsFull[m] = fullO[m];  obsCreate[m] = createO[m];  obsIssue[m] = issueO[m];
            obsLsuVld[m] = lsuVldO[m];  obsLsuPay[m] = lsuPayO[m];
            checkOutput("full", m, fullO[m], &mVld[m]);
            checkOutput("create_sel", m, createO[m], expCreate);
            checkOutput("issue_sel", m, issueO[m], expIssue);
            checkOutput("lsu_vld", m, lsuVldO[m], lsuVld[m]);
            checkOutput("lsu_payload", m, lsuPayO[m], lsuPay[m]);
            nextPick[m]   = pick;
            nextCreate[m] = cIdx;
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (flushS[m]) begin
                mVld[m]   = '0;
                lsuVld[m] = 1'b0;
            end else begin
                if (nextPick[m] >= 0) begin
                    lsuPay[m] = mPay[m][nextPick[m]];
                    lsuVld[m] = 1'b1;
                    mVld[m][nextPick[m]] = 1'b0;
                end else if (rdyS[m]) begin
                    lsuVld[m] = 1'b0;
                end
                if (nextCreate[m] >= 0) begin
                    mVld[m][nextCreate[m]]   = 1'b1;
                    mStamp[m][nextCreate[m]] = stampCtr;
                    mPay[m][nextCreate[m]]   = randPay();
                    stampCtr++;
                end
            end
        end
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        setStim(1'b0, '0, 1'b0, 1'b0);
        for (int m = 0; m < 2; m++) begin
            mVld[m]   = '0;
            lsuVld[m] = 1'b0;
            lsuPay[m] = '0;
        end
        applyStimulus();
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            checkOutput("reset_lsu_vld", m, lsuVldO[m], '0);
            checkOutput("reset_lsu_payload", m, lsuPayO[m], '0);
            checkOutput("reset_issue_sel", m, issueO[m], '0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < EN; i++) begin
                mPay[m][i]   = randPay();
                mStamp[m][i] = 0;
            end
        repeat (2) @(posedge clk);
        #1 doReset();

        setStim(1'b0, '0, 1'b1, 1'b0);
        runCycle();
        checkOutput("empty_issue", 0, obsIssue[0], '0);

        // Age order: e0,e1,e2 created back to back, then only e1/e2 ready.
        setStim(1'b1, '0, 1'b1, 1'b0);
        runCycle();  checkOutput("create_e0", 0, obsCreate[0], 8'h01);
        runCycle();  checkOutput("create_e1", 0, obsCreate[0], 8'h02);
        savedPay = mPay[0][1];
        runCycle();  checkOutput("create_e2", 0, obsCreate[0], 8'h04);
        setStim(1'b0, 8'b110, 1'b1, 1'b0);
        runCycle();
        checkOutput("age_pick_e1", 0, obsIssue[0], 8'h02);
        checkOutput("inorder_block", 1, obsIssue[1], 8'h00);
        setStim(1'b0, 8'b100, 1'b1, 1'b0);
        runCycle();
        checkOutput("age_pick_e2", 0, obsIssue[0], 8'h04);
        checkOutput("payload_e1", 0, obsLsuPay[0], savedPay);
        checkOutput("inorder_block2", 1, obsIssue[1], 8'h00);
        setStim(1'b0, 8'hff, 1'b1, 1'b0);
        runCycle();
        checkOutput("inorder_e0", 1, obsIssue[1], 8'h01);
        runCycle();
        checkOutput("inorder_e1", 1, obsIssue[1], 8'h02);
        checkOutput("empty_pick", 0, obsIssue[0], 8'h00);
        repeat (3) runCycle();

        // Backpressure: one issue fills the stage, then it holds until the LSU accepts.
        setStim(1'b1, '0, 1'b1, 1'b0);
        repeat (2) runCycle();
        setStim(1'b0, 8'hff, 1'b0, 1'b0);
        savedPay = mPay[0][0];
        runCycle();  checkOutput("bp_first_issue", 0, obsIssue[0], 8'h01);
        repeat (2) begin
            runCycle();
            checkOutput("bp_no_issue", 0, obsIssue[0], 8'h00);
            checkOutput("bp_payload_hold", 0, obsLsuPay[0], savedPay);
        end
        setStim(1'b0, 8'hff, 1'b1, 1'b0);
        runCycle();  checkOutput("bp_release_issue", 0, obsIssue[0], 8'h02);
        runCycle();  checkOutput("bp_vld_stays", 0, obsLsuVld[0], 1'b1);
        repeat (2) runCycle();

        // Full: eight creates, free e3, refill e3 which must then be youngest.
        setStim(1'b1, '0, 1'b1, 1'b0);
        repeat (8) runCycle();
        setStim(1'b0, 8'h08, 1'b1, 1'b0);
        runCycle();
        checkOutput("full_set", 0, obsFull[0], 1'b1);
        checkOutput("full_no_create", 0, obsCreate[0], 8'h00);
        checkOutput("full_issue_e3", 0, obsIssue[0], 8'h08);
        setStim(1'b1, '0, 1'b1, 1'b0);
        runCycle();
        checkOutput("full_drop", 0, obsFull[0], 1'b0);
        checkOutput("refill_e3", 0, obsCreate[0], 8'h08);
        setStim(1'b0, 8'hff, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            runCycle();
            if (k == 7) checkOutput("e3_youngest", 0, obsIssue[0], 8'h08);
        end
        repeat (8) runCycle();

        // Flush with a loaded stage and ready entries.
        setStim(1'b1, '0, 1'b1, 1'b0);
        repeat (2) runCycle();
        setStim(1'b0, 8'hff, 1'b0, 1'b0);
        runCycle();
        setStim(1'b1, 8'hff, 1'b1, 1'b1);
        runCycle();
        checkOutput("flush_issue", 0, obsIssue[0], 8'h00);
        checkOutput("flush_create", 0, obsCreate[0], 8'h00);
        checkOutput("flush_vld_before", 0, obsLsuVld[0], 1'b1);
        setStim(1'b0, '0, 1'b0, 1'b0);
        runCycle();
        checkOutput("flush_vld_after", 0, obsLsuVld[0], 1'b0);

        // Randomized traffic with one reset dropped into the middle of it.
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) doReset();
            for (int m = 0; m < 2; m++) begin
                sCreate[m] = ($urandom % 3) != 0;
                sReady[m]  = EN'($urandom);
                sRdy[m]    = ($urandom % 4) != 0;
                sFlush[m]  = ($urandom % 60) == 0;
            end
            runCycle();
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errCount);
        $finish;
    end

endmodule
